draw_arbiter: RTL and testbench
===============================

Name: draw_arbiter

Overview:
- Shares the single VGA framebuffer write port among up to NUM_REQ drawing engines: maze walls, player sprite, special plus/minus boxes, screen clear.
- Each engine uses a level-enable / done protocol: enable held high while drawing; engine emits x/y/colour each cycle; raises done when finished; clears done when enable drops.
- The arbiter grants one engine at a time (round-robin), sequences its enable, muxes and registers its pixel stream to the VGA adapter, and recovers from hung engines with a watchdog.

Parameters:
- NUM_REQ, 4, number of drawing engines.
- TIMEOUT_CYCLES, 4096, maximum cycles a grant may stay in DRAW before it is forcibly revoked.
- X_MAX, 319, largest plottable x.
- Y_MAX, 239, largest plottable y.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset.
- req  in  NUM_REQ  per-engine draw request, level.
- done_in  in  NUM_REQ  per-engine done flag.
- x_in  in  9*NUM_REQ  packed engine x; engine i at bits [9i+8:9i].
- y_in  in  9*NUM_REQ  packed engine y, same packing.
- colour_in  in  3*NUM_REQ  packed engine colour.
- enable  out  NUM_REQ  one-hot (or zero) engine enable.
- vga_x  out  9  pixel x to VGA adapter.
- vga_y  out  8  pixel y, low 8 bits of the selected y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe.
- busy  out  1  high in any state other than IDLE.
- active_id  out  2  index of the granted engine; width is clog2(NUM_REQ).
- timeout_err  out  1  sticky: a watchdog revoke has occurred.

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. On reset:
  - state=IDLE; enable=0; all vga_* outputs=0; busy=0; active_id=0; timeout_err=0.
  - Round-robin pointer=0; watchdog=0.
  - Reset mid-draw drops enable in the same edge, with no release cycle.
- States:
  - IDLE: if req≠0, pick a winner by round-robin (first set bit at or after ptr, wrapping), register active_id and set enable[winner]=1. Then → SETUP. Else stay.
  - SETUP: one cycle. Lets the engine's registered outputs become valid. vga_plot=0. Then → DRAW.
  - DRAW:
    - Pixel path: vga_x/y/colour <= selected inputs; vga_plot <= ~done_in[id] & x≤X_MAX & y≤Y_MAX. Out-of-range pixels are clipped, not wrapped.
    - On done_in[id]=1: → RELEASE. Same-cycle done and pixel: the pixel is dropped.
    - On watchdog = TIMEOUT_CYCLES-1 without done: → RELEASE and set timeout_err.
  - RELEASE: enable=0 and vga_plot=0 for exactly one cycle, so the engine clears done. ptr <= id+1 mod NUM_REQ. Then → IDLE.
- Timing:
  - Pixel latency: engine output → vga pins is 1 register stage.
  - Grant latency: req rising in IDLE at edge t gives enable at t+1 and the first possible plot at t+3.
- Request rules:
  - A req dropped while granted is ignored. The grant persists until done or timeout.
  - Simultaneous requests: lowest index at or after ptr wins. Losers wait; no request is lost while held.
  - Back-to-back: minimum 2 non-drawing cycles (RELEASE, IDLE) between grants.
- Watchdog: 13-bit counter, cleared on entry to SETUP, counts in DRAW only.

Decomposition:
- Package draw_arb_pkg: state enum (IDLE, SETUP, DRAW, RELEASE), X_MAX/Y_MAX screen constants, colour constants (WHITE 3'b111, GREEN 3'b010, RED 3'b100), and the packed-field width constants.
- Sub-module rr_picker: combinational. Inputs req and ptr; outputs winner index and a valid flag.

Test Plan:
1. Single request: req=4'b0100; engine 2 emits 81 pixels then done → enable[2] for SETUP+DRAW, exactly 81 vga_plot pulses, RELEASE, busy falls. The next rr pointer is 3.
2. Contention: req=4'b1011 held, ptr=0 → grants in order 0,1,3,0. Each grant is separated by ≥2 idle cycles and never overlaps.
3. Clipping: engine drives x=330, y=100 then x=319, y=239 → no plot for the first pixel; plot with vga_x=319, vga_y=239 for the second.
4. Hung engine: done never asserted → revoke after 4096 DRAW cycles, timeout_err=1 and sticky. The next requester is then granted normally.
5. Reset mid-draw: resetn=0 during DRAW of engine 1 → next edge enable=0, vga_plot=0, state IDLE, timeout_err=0, ptr=0.
6. Done on the first DRAW cycle: done_in high at DRAW entry → zero plots, RELEASE, IDLE.

Source files
------------

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the framebuffer draw arbiter: FSM states,
// screen limits, palette and the widths of the packed per-engine fields.
package draw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_DRAW    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int SCREEN_X_MAX = 319;
    localparam int SCREEN_Y_MAX = 239;

    localparam int X_W     = 9;
    localparam int Y_W     = 9;
    localparam int COL_W   = 3;
    localparam int VGA_Y_W = 8;
    localparam int WDOG_W  = 13;

    localparam logic [COL_W-1:0] WHITE = 3'b111;
    localparam logic [COL_W-1:0] GREEN = 3'b010;
    localparam logic [COL_W-1:0] RED   = 3'b100;

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_picker #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [ID_W-1:0] w_idx;

    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[w_idx]) begin
                valid  = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Shares the single VGA write port among NUM_REQ drawing engines: round-robin
// grant, enable sequencing, registered pixel mux with clipping, and a watchdog.
module draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 4096,
    parameter int  X_MAX          = SCREEN_X_MAX,
    parameter int  Y_MAX          = SCREEN_Y_MAX,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done_in,
    input  logic [X_W*NUM_REQ-1:0]   x_in,
    input  logic [Y_W*NUM_REQ-1:0]   y_in,
    input  logic [COL_W*NUM_REQ-1:0] colour_in,
    output logic [NUM_REQ-1:0]       enable,
    output logic [X_W-1:0]           vga_x,
    output logic [VGA_Y_W-1:0]       vga_y,
    output logic [COL_W-1:0]         vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic [ID_W-1:0]          active_id,
    output logic                     timeout_err
);

    state_t               r_state;
    state_t               w_next_state;
    logic [NUM_REQ-1:0]   r_enable;
    logic [NUM_REQ-1:0]   w_grant_onehot;
    logic [ID_W-1:0]      r_active_id;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      w_winner;
    logic                 w_valid;
    logic [WDOG_W-1:0]    r_wdog;
    logic [X_W-1:0]       r_vga_x;
    logic [VGA_Y_W-1:0]   r_vga_y;
    logic [COL_W-1:0]     r_vga_colour;
    logic                 r_vga_plot;
    logic                 r_timeout_err;
    logic [X_W-1:0]       w_sel_x;
    logic [Y_W-1:0]       w_sel_y;
    logic [COL_W-1:0]     w_sel_colour;
    logic                 w_sel_done;
    logic                 w_timeout;
    logic                 w_pixel_ok;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    always_comb begin
        w_grant_onehot           = '0;
        w_grant_onehot[w_winner] = 1'b1;
    end

    // Mux the granted engine's packed fields; decoded rather than indexed so
    // the select stays width-exact for any NUM_REQ.
    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        w_sel_done   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_active_id == ID_W'(i)) begin
                w_sel_x      = x_in[i*X_W +: X_W];
                w_sel_y      = y_in[i*Y_W +: Y_W];
                w_sel_colour = colour_in[i*COL_W +: COL_W];
                w_sel_done   = done_in[i];
            end
        end
    end

    // Full 9-bit y is compared so rows past the screen clip instead of wrapping.
    assign w_pixel_ok = (w_sel_x <= X_W'(X_MAX)) && (w_sel_y <= Y_W'(Y_MAX));

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE:    if (w_valid) w_next_state = ST_SETUP;
            ST_SETUP:   w_next_state = ST_DRAW;
            ST_DRAW: begin
                if (w_sel_done) begin
                    w_next_state = ST_RELEASE;
                end else if (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list carries only the clock edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_enable      <= '0;
            r_active_id   <= '0;
            r_ptr         <= '0;
            r_wdog        <= '0;
            r_vga_x       <= '0;
            r_vga_y       <= '0;
            r_vga_colour  <= '0;
            r_vga_plot    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_vga_plot <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_active_id <= w_winner;
                        r_enable    <= w_grant_onehot;
                        r_wdog      <= '0;
                    end
                end
                ST_DRAW: begin
                    r_vga_x      <= w_sel_x;
                    r_vga_y      <= w_sel_y[VGA_Y_W-1:0];
                    r_vga_colour <= w_sel_colour;
                    // The pixel that arrives alongside done (or on the revoke
                    // cycle) is dropped so RELEASE never shows a plot.
                    r_vga_plot   <= !w_sel_done && !w_timeout && w_pixel_ok;
                    r_wdog       <= r_wdog + 1'b1;
                    if (w_next_state == ST_RELEASE) r_enable <= '0;
                    if (w_timeout) r_timeout_err <= 1'b1;
                end
                ST_RELEASE: begin
                    r_ptr <= (r_active_id == ID_W'(NUM_REQ - 1)) ? '0 : r_active_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign enable      = r_enable;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign vga_plot    = r_vga_plot;
    assign busy        = (r_state != ST_IDLE);
    assign active_id   = r_active_id;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_draw_arbiter;
    import draw_arb_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 4096;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  req;
    logic [N-1:0]  done_in;
    logic [9*N-1:0] x_in;
    logic [9*N-1:0] y_in;
    logic [3*N-1:0] colour_in;
    logic [N-1:0]  enable;
    logic [8:0]    vga_x;
    logic [7:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic          busy;
    logic [1:0]    active_id;
    logic          timeout_err;

    draw_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done_in(done_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .enable(enable), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .active_id(active_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- engine stimulus ----------------
    int eng_n   [N];
    int eng_cnt [N];
    int clip_eng = -1;

    function automatic logic [2:0] eng_col(input int i);
        case (i)
            0:       return WHITE;
            1:       return GREEN;
            2:       return RED;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [8:0] px_x(input int i, input int k);
        if (i == clip_eng) begin
            case (k)
                0:       return 9'd330;
                1:       return 9'd319;
                default: return 9'd5;
            endcase
        end
        return 9'(k % 320);
    endfunction

    function automatic logic [8:0] px_y(input int i, input int k);
        if (i == clip_eng) begin
            case (k)
                0:       return 9'd100;
                1:       return 9'd239;
                default: return 9'd240;
            endcase
        end
        return 9'((k * 3 + i) % 240);
    endfunction

    // Engine sees enable, then emits pixel k on its k-th DRAW cycle; done
    // once its pixel list is exhausted, cleared as soon as enable drops.
    task automatic drive_engines();
        int pix;
        for (int i = 0; i < N; i++) begin
            if (enable[i] === 1'b1) begin
                pix = (eng_cnt[i] == 0) ? 0 : eng_cnt[i] - 1;
                if (pix < eng_n[i]) begin
                    x_in[i*9 +: 9]      = px_x(i, pix);
                    y_in[i*9 +: 9]      = px_y(i, pix);
                    colour_in[i*3 +: 3] = eng_col(i);
                    done_in[i]          = 1'b0;
                end else begin
                    done_in[i] = 1'b1;
                end
                eng_cnt[i]++;
            end else begin
                eng_cnt[i] = 0;
                done_in[i] = 1'b0;
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the grant as an owner plus age in cycles since the grant edge
    // (age 0 = setup cycle, age >= 1 = drawing), and one cool-down cycle.
    bit         m_live = 1'b0;
    int         m_owner = -1;
    int         m_age, m_ptr, m_id;
    bit         m_releasing, m_err, m_plot;
    logic [8:0] m_x;
    logic [7:0] m_y;
    logic [2:0] m_col;
    int         m_px, m_py;
    bit         m_done, m_found;

    always @(posedge clk) begin
        m_live = 1'b1;
        if (resetn !== 1'b1) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_id = 0;
            m_releasing = 0; m_err = 0; m_plot = 0;
        end else begin
            m_plot = 0;
            if (m_owner >= 0) begin
                if (m_age >= 1) begin
                    m_done = done_in[m_owner];
                    m_px   = int'(x_in[m_owner*9 +: 9]);
                    m_py   = int'(y_in[m_owner*9 +: 9]);
                    if (m_done || m_age == TMO) begin
                        if (!m_done) m_err = 1;
                        m_ptr       = (m_owner + 1) % N;
                        m_owner     = -1;
                        m_releasing = 1;
                    end else begin
                        m_plot = (m_px <= 319) && (m_py <= 239);
                        m_x    = 9'(m_px);
                        m_y    = 8'(m_py % 256);
                        m_col  = colour_in[m_owner*3 +: 3];
                    end
                end
                m_age++;
            end else if (m_releasing) begin
                m_releasing = 0;
            end else if (req != 0) begin
                m_found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!m_found && req[(m_ptr + k) % N]) begin
                        m_found = 1;
                        m_owner = (m_ptr + k) % N;
                        m_id    = m_owner;
                        m_age   = 0;
                    end
                end
            end
        end
    end

    task automatic cmp();
        logic [N-1:0] exp_en;
        if (!m_live) return;
        exp_en = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("enable", 32'(enable), 32'(exp_en));
        check("busy", 32'(busy), 32'((m_owner >= 0) || m_releasing));
        check("active_id", 32'(active_id), 32'(m_id));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("vga_plot", 32'(vga_plot), 32'(m_plot));
        check("enable_onehot0", 32'($onehot0(enable)), 32'd1);
        if (m_plot) begin
            check("vga_x", 32'(vga_x), 32'(m_x));
            check("vga_y", 32'(vga_y), 32'(m_y));
            check("vga_colour", 32'(vga_colour), 32'(m_col));
        end
    endtask

    // ---------------- monitor ----------------
    int          grant_log[$];
    int          plot_cnt = 0;
    int          zero_run = 0;
    bit          have_granted = 1'b0;
    logic [N-1:0] prev_en = '0;
    logic [8:0]  last_x;
    logic [7:0]  last_y;

    task automatic mon();
        if (enable != 0 && prev_en == 0) begin
            grant_log.push_back(int'(active_id));
            if (have_granted) check("grant_gap_ge2", 32'(zero_run >= 2), 32'd1);
            have_granted = 1'b1;
        end
        zero_run = (enable == 0) ? zero_run + 1 : 0;
        prev_en  = enable;
        if (vga_plot === 1'b1) begin
            plot_cnt++;
            last_x = vga_x;
            last_y = vga_y;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cmp();
        mon();
        drive_engines();
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (enable == 0 && n < 200) begin
            step();
            n++;
        end
        check(name, 32'(enable != 0), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy !== 1'b0 && n < budget);
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic set_all_n(input int v);
        for (int i = 0; i < N; i++) eng_n[i] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        resetn = 1'b0; req = '0; done_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        set_all_n(2);
        for (int i = 0; i < N; i++) eng_cnt[i] = 0;

        // Reset state
        step(); step();
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vga_x", 32'(vga_x), 32'd0);
        check("rst_vga_y", 32'(vga_y), 32'd0);
        check("rst_vga_colour", 32'(vga_colour), 32'd0);
        check("rst_vga_plot", 32'(vga_plot), 32'd0);
        check("rst_active_id", 32'(active_id), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        resetn = 1'b1;
        step();

        // 1: single request, 81 pixels, pointer moves to 3
        eng_n[2] = 81; plot_cnt = 0;
        req = 4'b0100;
        wait_grant("t1_grant");
        check("t1_active_id", 32'(active_id), 32'd2);
        req = '0;
        wait_idle("t1_idle", 300);
        check("t1_plots", 32'(plot_cnt), 32'd81);
        set_all_n(2);
        req = 4'b1111;
        wait_grant("t1_ptr_grant");
        check("t1_ptr_next_is_3", 32'(active_id), 32'd3);
        req = '0;
        wait_idle("t1_ptr_idle", 100);

        // 2: contention from ptr=0
        resetn = 1'b0; step(); step(); resetn = 1'b1; step();
        set_all_n(4);
        grant_log.delete();
        req = 4'b1011;
        for (int n = 0; n < 400 && grant_log.size() < 4; n++) step();
        req = '0;
        wait_idle("t2_idle", 100);
        check("t2_grant_count", 32'(grant_log.size() >= 4), 32'd1);
        if (grant_log.size() >= 4) begin
            check("t2_grant0", 32'(grant_log[0]), 32'd0);
            check("t2_grant1", 32'(grant_log[1]), 32'd1);
            check("t2_grant2", 32'(grant_log[2]), 32'd3);
            check("t2_grant3", 32'(grant_log[3]), 32'd0);
        end

        // 3: clipping
        clip_eng = 1; eng_n[1] = 3; plot_cnt = 0;
        req = 4'b0010;
        wait_grant("t3_grant");
        req = '0;
        wait_idle("t3_idle", 100);
        check("t3_plots", 32'(plot_cnt), 32'd1);
        check("t3_last_x", 32'(last_x), 32'd319);
        check("t3_last_y", 32'(last_y), 32'd239);
        clip_eng = -1;

        // 6: done on first DRAW cycle
        eng_n[0] = 0; plot_cnt = 0;
        req = 4'b0001;
        wait_grant("t6_grant");
        check("t6_active_id", 32'(active_id), 32'd0);
        req = '0;
        wait_idle("t6_idle", 50);
        check("t6_plots", 32'(plot_cnt), 32'd0);

        // 4: hung engine, watchdog revoke, sticky error
        eng_n[2] = 1 << 30; plot_cnt = 0;
        req = 4'b0100;
        wait_grant("t4_grant");
        req = '0;
        wait_idle("t4_idle", 5000);
        check("t4_timeout_err", 32'(timeout_err), 32'd1);
        check("t4_plots", 32'(plot_cnt), 32'd4095);
        eng_n[3] = 5; plot_cnt = 0;
        req = 4'b1000;
        wait_grant("t4_next_grant");
        check("t4_next_id", 32'(active_id), 32'd3);
        req = '0;
        wait_idle("t4_next_idle", 100);
        check("t4_next_plots", 32'(plot_cnt), 32'd5);
        check("t4_err_sticky", 32'(timeout_err), 32'd1);

        // 5: reset mid-draw
        eng_n[1] = 50;
        req = 4'b0010;
        wait_grant("t5_grant");
        req = '0;
        repeat (10) step();
        check("t5_drawing", 32'(enable), 32'h2);
        resetn = 1'b0;
        step();
        check("t5_enable", 32'(enable), 32'd0);
        check("t5_plot", 32'(vga_plot), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_timeout_err", 32'(timeout_err), 32'd0);
        step();
        resetn = 1'b1;
        set_all_n(3);
        req = 4'b1111;
        wait_grant("t5_regrant");
        check("t5_ptr_zero", 32'(active_id), 32'd0);
        req = '0;
        wait_idle("t5_idle", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
